// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time-setting controller, the
// seconds..years counter chain and the display mux.
//   - state_e     : controller state codes (RUN=0, SET_SEC=1 .. SET_YEAR=6)
//   - NUM_FIELDS  : number of editable fields (6)
//   - INC_*_BIT   : bit positions of the one-hot increment bus
//   - is_set_state, next_on_mode, field_onehot : small helpers
package time_pkg;

  localparam int NUM_FIELDS = 6;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_SEC  = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_HOUR = 3'd3,
    ST_SET_DAY  = 3'd4,
    ST_SET_MON  = 3'd5,
    ST_SET_YEAR = 3'd6
  } state_e;

  // One-hot increment bus bit mapping.
  localparam int INC_SEC_BIT  = 0;
  localparam int INC_MIN_BIT  = 1;
  localparam int INC_HOUR_BIT = 2;
  localparam int INC_DAY_BIT  = 3;
  localparam int INC_MON_BIT  = 4;
  localparam int INC_YEAR_BIT = 5;

  // True for the six editing states only; code 7 is not a set state.
  function automatic logic is_set_state(input state_e s);
    logic r;
    r = (s != ST_RUN) && (3'(s) <= 3'(ST_SET_YEAR));
    return r;
  endfunction

  // Field sequence advanced by the mode key; anything unknown recovers to RUN.
  function automatic state_e next_on_mode(input state_e s);
    state_e r;
    case (s)
      ST_RUN:      r = ST_SET_SEC;
      ST_SET_SEC:  r = ST_SET_MIN;
      ST_SET_MIN:  r = ST_SET_HOUR;
      ST_SET_HOUR: r = ST_SET_DAY;
      ST_SET_DAY:  r = ST_SET_MON;
      ST_SET_MON:  r = ST_SET_YEAR;
      default:     r = ST_RUN;
    endcase
    return r;
  endfunction

  // Increment bit for the field being edited; all-zero outside set states.
  function automatic logic [NUM_FIELDS-1:0] field_onehot(input state_e s);
    logic [NUM_FIELDS-1:0] r;
    r = '0;
    case (s)
      ST_SET_SEC:  r[INC_SEC_BIT]  = 1'b1;
      ST_SET_MIN:  r[INC_MIN_BIT]  = 1'b1;
      ST_SET_HOUR: r[INC_HOUR_BIT] = 1'b1;
      ST_SET_DAY:  r[INC_DAY_BIT]  = 1'b1;
      ST_SET_MON:  r[INC_MON_BIT]  = 1'b1;
      ST_SET_YEAR: r[INC_YEAR_BIT] = 1'b1;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// key_repeat: turns a held key level into increment pulses.
//   A rising edge of level gives one pulse in the next cycle. While level
//   stays high, the first repeat follows REP_START cycles after that pulse,
//   then one pulse every REP_RATE cycles.
//   clr aborts the repeat and consumes the current level, so a key already
//   held when clr drops produces nothing until it is released and pressed
//   again.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   level : debounced key level
//   clr   : abort / re-arm request
//   pulse : registered one-cycle increment pulse
module key_repeat #(
  parameter int REP_START = 500,
  parameter int REP_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clr,
  output logic pulse
);

  localparam int MAXV = (REP_START > REP_RATE) ? REP_START : REP_RATE;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] START_TERM = CW'(REP_START - 1);
  localparam logic [CW-1:0] RATE_TERM  = CW'(REP_RATE - 1);

  logic          level_q;
  logic          armed_q, armed_d;
  logic          phase_q, phase_d;   // 0: waiting for first repeat, 1: steady rate
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] term;

  assign term = phase_q ? RATE_TERM : START_TERM;

  always_comb begin
    armed_d = armed_q;
    phase_d = phase_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (clr || !level) begin
      armed_d = 1'b0;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (!level_q) begin
      // fresh press
      pulse_d = 1'b1;
      armed_d = 1'b1;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (armed_q) begin
      if (cnt_q == term) begin
        pulse_d = 1'b1;
        phase_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
      phase_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level;
      armed_q <= armed_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: clock/calendar time-setting controller.
//   RUN lets the counter chain count. Each mode press walks through the six
//   set states (sec, min, hour, day, month, year) and back to RUN. In a set
//   state, the increment key drives a one-hot pulse for the edited field,
//   with auto-repeat. An idle set state returns to RUN after TIMEOUT_S
//   one-second ticks. blink_o toggles once per second while editing.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   mode_i         : one-cycle pulse, advance edit field
//   inc_i          : increment key level
//   tick_1hz_i     : one-cycle pulse per second
//   run_en_o       : count enable for the counter chain (registered)
//   field_o        : current state code (also the FSM debug view)
//   inc_o          : one-hot increment pulse, bit0 sec .. bit5 year
//   blink_o        : blink phase for the edited field
//
// Handshake: there is no valid/ready flow here; all inputs are single-cycle
// pulses or levels sampled every clock, and inc_o is a one-cycle strobe that
// the counter chain must accept unconditionally.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int REP_START = 500,
  parameter int REP_RATE  = 100,
  parameter int TIMEOUT_S = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_i,
  input  logic                  inc_i,
  input  logic                  tick_1hz_i,
  output logic                  run_en_o,
  output logic [2:0]            field_o,
  output logic [NUM_FIELDS-1:0] inc_o,
  output logic                  blink_o
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_S - 1);

  state_e        state_q, state_d;
  logic          run_en_q, run_en_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic in_set;
  logic state_chg;
  logic timeout_hit;
  logic rep_clr;
  logic rep_pulse;

  assign in_set = is_set_state(state_q);

  // This tick would bring the idle count to TIMEOUT_S; any key press
  // in the same cycle restarts the idle count instead.
  assign timeout_hit = in_set && tick_1hz_i && !mode_i && !inc_i &&
                       (to_cnt_q == TO_TERM);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      run_en_q <= 1'b1;
      blink_q  <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      run_en_q <= run_en_d;
      blink_q  <= blink_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state (mode has priority over timeout)
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!in_set && state_q != ST_RUN) begin
      state_d = ST_RUN;
    end else if (mode_i) begin
      state_d = next_on_mode(state_q);
    end else if (timeout_hit) begin
      state_d = ST_RUN;
    end
  end

  assign state_chg = (state_d != state_q);

  // Idle timeout and blink phase
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!in_set || state_chg || mode_i || inc_i) begin
      to_cnt_d = '0;
    end else if (tick_1hz_i) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (state_d == ST_RUN || state_chg) begin
      blink_d = 1'b0;
    end else if (tick_1hz_i) begin
      blink_d = ~blink_q;
    end
  end

  assign run_en_d = (state_d == ST_RUN);

  // Repeat engine is held clear in RUN and on every state change, so a
  // key held across a transition needs a fresh press in the new field.
  assign rep_clr = state_chg || !in_set;

  key_repeat #(
    .REP_START (REP_START),
    .REP_RATE  (REP_RATE)
  ) u_key_repeat (
    .clk   (clk),
    .rst   (rst),
    .level (inc_i),
    .clr   (rep_clr),
    .pulse (rep_pulse)
  );

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    run_en_o = run_en_q;
    field_o  = 3'(state_q);
    blink_o  = blink_q;
    inc_o    = '0;
    if (rep_pulse && in_set) begin
      inc_o = field_onehot(state_q);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with REP_START=5, REP_RATE=3, TIMEOUT_S=4.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// edge that should have produced them.
module tb_time_set_ctrl;

  localparam int REP_START = 5;
  localparam int REP_RATE  = 3;
  localparam int TIMEOUT_S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_i = 1'b0;
  logic       inc_i = 1'b0;
  logic       tick_1hz_i = 1'b0;
  logic       run_en_o;
  logic [2:0] field_o;
  logic [5:0] inc_o;
  logic       blink_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];

  time_set_ctrl #(
    .REP_START (REP_START),
    .REP_RATE  (REP_RATE),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (mode_i),
    .inc_i      (inc_i),
    .tick_1hz_i (tick_1hz_i),
    .run_en_o   (run_en_o),
    .field_o    (field_o),
    .inc_o      (inc_o),
    .blink_o    (blink_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    mode_i = 1'b1;
    step();
    mode_i = 1'b0;
  endtask

  initial begin
    logic [5:0] e;

    // ---------------- reset ----------------
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_run_en", 32'(run_en_o), 32'd1);
    check_eq("rst_field",  32'(field_o),  32'd0);
    check_eq("rst_inc",    32'(inc_o),    32'd0);
    check_eq("rst_blink",  32'(blink_o),  32'd0);
    step();
    check_eq("idle_field", 32'(field_o), 32'd0);

    // inc_i ignored in RUN
    inc_i = 1'b1;
    step();
    check_eq("run_inc_ignored", 32'(inc_o), 32'd0);
    step();
    inc_i = 1'b0;
    step();

    // ---------------- field cycling ----------------
    for (int i = 1; i <= 7; i++) begin
      pulse_mode();
      check_eq($sformatf("cyc_field%0d", i), 32'(field_o), 32'(i % 7));
      check_eq($sformatf("cyc_run_en%0d", i), 32'(run_en_o), (i % 7 == 0) ? 32'd1 : 32'd0);
    end

    // ---------------- held increment in SET_MIN ----------------
    pulse_mode();
    pulse_mode();
    check_eq("held_field", 32'(field_o), 32'd2);
    for (int k = 0; k < 17; k++) begin
      e = (k == 0 || k == 5 || k == 8 || k == 11 || k == 14) ? 6'b000010 : 6'b000000;
      exp_q.push_back(e);
    end
    inc_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k == 15) inc_i = 1'b0;
      step();
      e = exp_q.pop_front();
      check_eq($sformatf("held_inc_c%0d", k + 1), 32'(inc_o), 32'(e));
    end
    check_eq("held_field_after", 32'(field_o), 32'd2);

    // ---------------- timeout in SET_HOUR ----------------
    pulse_mode();
    check_eq("to_field_entry", 32'(field_o), 32'd3);
    check_eq("to_blink_entry", 32'(blink_o), 32'd0);
    for (int t = 1; t <= 4; t++) begin
      step();
      step();
      check_eq($sformatf("to_idle_field%0d", t), 32'(field_o), 32'd3);
      tick_1hz_i = 1'b1;
      step();
      tick_1hz_i = 1'b0;
      if (t < 4) begin
        check_eq($sformatf("to_field_t%0d", t), 32'(field_o), 32'd3);
        check_eq($sformatf("to_blink_t%0d", t), 32'(blink_o), 32'(t % 2));
      end else begin
        check_eq("to_field_run", 32'(field_o),  32'd0);
        check_eq("to_run_en",    32'(run_en_o), 32'd1);
        check_eq("to_blink_run", 32'(blink_o),  32'd0);
      end
    end
    step();
    check_eq("to_stays_run", 32'(field_o), 32'd0);

    // ---------------- mode + inc edge together in SET_SEC ----------------
    pulse_mode();
    check_eq("sim_field_sec", 32'(field_o), 32'd1);
    mode_i = 1'b1;
    inc_i  = 1'b1;
    step();
    mode_i = 1'b0;
    check_eq("sim_field_min", 32'(field_o), 32'd2);
    check_eq("sim_inc_none",  32'(inc_o),   32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      check_eq($sformatf("sim_no_repeat%0d", k), 32'(inc_o), 32'd0);
    end
    inc_i = 1'b0;
    step();

    // fresh press, then reset in the middle of the repeat
    inc_i = 1'b1;
    step();
    check_eq("rr_first", 32'(inc_o), 32'b000010);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rr_field",  32'(field_o),  32'd0);
    check_eq("rr_run_en", 32'(run_en_o), 32'd1);
    check_eq("rr_blink",  32'(blink_o),  32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq($sformatf("rr_no_pulse%0d", k), 32'(inc_o), 32'd0);
    end
    inc_i = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter REP_START, default 500: consecutive inc_i-high cycles before auto-repeat begins.
REQ-002 Parameter REP_RATE, default 100: cycles between auto-repeat pulses.
REQ-003 Parameter TIMEOUT_S, default 30: idle tick_1hz_i pulses in a set state before the block returns to RUN.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mode_i  input  1  one-cycle pulse, debounced; advances the edit field.
REQ-007 inc_i  input  1  level, synchronised and debounced; increment request.
REQ-008 tick_1hz_i  input  1  one-cycle pulse once per second from the prescaler.
REQ-009 run_en_o  output  1  count enable to the s/min/hour/day/month/year counter chain.
REQ-010 field_o  output  3  current state code, for display select.
REQ-011 inc_o  output  6  one-hot increment pulse; bit0 sec, bit1 min, bit2 hour, bit3 day, bit4 month, bit5 year.
REQ-012 blink_o  output  1  blink phase for the field being edited.

Function
REQ-013 The FSM SHALL have 7 states, with codes RUN=0, SET_SEC=1, SET_MIN=2, SET_HOUR=3, SET_DAY=4, SET_MON=5 and SET_YEAR=6; codes 7+ are unreachable and recover to RUN.
REQ-014 On mode_i, the state SHALL advance as follows: RUN->SET_SEC->SET_MIN->...->SET_YEAR->RUN, taking effect the next cycle.
REQ-015 run_en_o SHALL be registered and equal to 1 only in RUN; field_o SHALL equal the current state code.
REQ-016 In a set state, an inc_i rising edge SHALL produce a 1-cycle pulse on inc_o[state-1] in the following cycle (latency 1).
REQ-017 While inc_i stays high, the first repeat pulse SHALL occur REP_START cycles after the initial pulse, followed by one pulse every REP_RATE cycles.
REQ-018 The repeat counter SHALL clear when inc_i falls, when the state changes, or on rst.
REQ-019 inc_o SHALL be all-zero in RUN (inc_i ignored), and at most one inc_o bit SHALL be high in any cycle.
REQ-020 If mode_i and an inc_i rising edge occur in the same cycle, mode SHALL take priority: no inc pulse is issued, and the repeat restarts only after the next inc_i rising edge in the new state.
REQ-021 The timeout counter SHALL count tick_1hz_i only in set states, and SHALL clear on any cycle where mode_i=1 or inc_i=1, and on every state change.
REQ-022 When the timeout count reaches TIMEOUT_S, the state SHALL become RUN on the next cycle; if mode_i arrives in that same cycle, the mode transition SHALL win.
REQ-023 blink_o SHALL be 0 in RUN, SHALL clear to 0 on entry to any set state, and SHALL toggle on each tick_1hz_i while in a set state.
REQ-024 Counter widths SHALL be sized from the parameters ($clog2), with no wrap before the terminal count.

Reset
REQ-025 With rst=1 at a clock edge, the next cycle SHALL show: state RUN, run_en_o=1, field_o=0, inc_o=0, blink_o=0, and all counters 0.
REQ-026 rst asserted mid-repeat or mid-set SHALL abort the operation with no further inc_o pulse.
REQ-027 rst SHALL override mode_i, inc_i and tick_1hz_i in the same cycle.

Structure
REQ-028 The state codes, field count (6) and one-hot bit mapping SHALL live in the shared package time_pkg, also used by the counter chain and display mux.
REQ-029 Auto-repeat SHALL be a sub-module, key_repeat (inputs: clk, rst, level, clr; output: pulse), parameterised by REP_START/REP_RATE.
REQ-030 The FSM, timeout counter and blink logic SHALL stay in time_set_ctrl.

Verification (REP_START=5, REP_RATE=3, TIMEOUT_S=4)
REQ-031 Reset: rst high 2 cycles, then low -> run_en_o=1, field_o=0, inc_o=0, blink_o=0.
REQ-032 Field cycling: 7 mode_i pulses -> field_o steps 1,2,3,4,5,6,0; run_en_o=0 for codes 1..6.
REQ-033 Held increment: in SET_MIN, inc_i held 15 cycles -> inc_o=6'b000010 at cycles 1, 6, 9, 12, 15 after the edge; no other bits ever set.
REQ-034 Timeout: in SET_HOUR with no input, 4 tick_1hz_i pulses -> state RUN one cycle after the 4th; blink_o toggles 3 times and then reads 0 in RUN.
REQ-035 Simultaneous events: mode_i coincident with an inc_i edge in SET_SEC -> field_o=2 and inc_o=0; rst during a held repeat -> no pulse after rst.
